// File: rtl/board_rst_wake_cond_pkg.sv
// Shared state encoding and default timing constants for the board
// reset/wake input conditioner.
package board_cond_pkg;

    localparam int unsigned STATE_W          = 2;
    localparam int unsigned DEF_DEBOUNCE_CYC = 16000;
    localparam int unsigned DEF_RST_STRETCH  = 256;

    typedef enum logic [STATE_W-1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } rst_state_e;

endpackage

// File: rtl/board_rst_wake_cond_pad_debounce.sv
// Synchroniser plus debouncer for one raw board pad; the accepted level only
// changes after the synchronised input has differed for DEBOUNCE_CYC cycles.
module pad_debounce
    import board_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter logic        RST_VAL      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_raw,
    output logic dout,
    output logic rise
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din_raw};
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        // Any cycle agreeing with the accepted level restarts the qualification.
        if (s != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{RST_VAL}};
            cnt_q   <= '0;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign dout = level_q;
    assign rise = rise_q;

endmodule

// File: rtl/board_rst_wake_cond.sv
// Board reset/wake conditioner: debounced buttons feed a reset sequencer that
// stretches the SoC AON reset; the wake pad is conditioned independently.
module board_rst_wake_cond
    import board_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned RST_STRETCH  = DEF_RST_STRETCH,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fpga_rst_n_raw,
    input  logic               mcu_rst_n_raw,
    input  logic               wakeup_raw,
    output logic               soc_erst_n,
    output logic               dwakeup_n,
    output logic               wake_pulse,
    output logic [STATE_W-1:0] rst_state
);

    localparam int unsigned      STR_W    = $clog2(RST_STRETCH + 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(RST_STRETCH - 1);

    logic       fpga_lvl, mcu_lvl, wake_lvl, wake_rise, btn_ok;
    logic [1:0] btn_rise_unused;

    rst_state_e       state_q, state_d;
    logic [STR_W-1:0] scnt_q, scnt_d;
    logic             soc_erst_n_q, soc_erst_n_d;
    logic             dwakeup_n_q, dwakeup_n_d;
    logic             wake_pulse_q, wake_pulse_d;

    pad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b1)) u_fpga_db (
        .clk(clk), .rst_n(rst_n), .din_raw(fpga_rst_n_raw), .dout(fpga_lvl), .rise(btn_rise_unused[0])
    );
    pad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b1)) u_mcu_db (
        .clk(clk), .rst_n(rst_n), .din_raw(mcu_rst_n_raw), .dout(mcu_lvl), .rise(btn_rise_unused[1])
    );
    pad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b0)) u_wake_db (
        .clk(clk), .rst_n(rst_n), .din_raw(wakeup_raw), .dout(wake_lvl), .rise(wake_rise)
    );

    assign btn_ok = fpga_lvl & mcu_lvl;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            HOLD: begin
                if (btn_ok) begin
                    state_d = STRETCH;
                    scnt_d  = '0;
                end
            end
            STRETCH: begin
                // A fresh press outranks stretch completion in the same cycle.
                if (!btn_ok) begin
                    state_d = HOLD;
                    scnt_d  = '0;
                end else if (scnt_q >= STR_LAST) begin
                    state_d = RUN;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!btn_ok) state_d = HOLD;
            end
            default: state_d = HOLD;
        endcase
        soc_erst_n_d = (state_d == RUN);
        dwakeup_n_d  = ~wake_lvl;
        wake_pulse_d = wake_rise && (state_q == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HOLD;
            scnt_q       <= '0;
            soc_erst_n_q <= 1'b0;
            dwakeup_n_q  <= 1'b1;
            wake_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scnt_q       <= scnt_d;
            soc_erst_n_q <= soc_erst_n_d;
            dwakeup_n_q  <= dwakeup_n_d;
            wake_pulse_q <= wake_pulse_d;
        end
    end

    assign soc_erst_n = soc_erst_n_q;
    assign dwakeup_n  = dwakeup_n_q;
    assign wake_pulse = wake_pulse_q;
    assign rst_state  = state_q;

endmodule

// File: tb/tb_board_rst_wake_cond.sv
// Self-checking bench for board_rst_wake_cond using a window-based reference
// model of debounce, reset stretch and wake gating.
module tb_board_rst_wake_cond;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int RS   = 4;
    localparam int HW   = SYNC + DEB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fpga_rst_n_raw = 1'b1;
    logic       mcu_rst_n_raw = 1'b1;
    logic       wakeup_raw = 1'b0;
    logic       soc_erst_n, dwakeup_n, wake_pulse;
    logic [1:0] rst_state;

    int checks = 0;
    int errors = 0;

    // Reference model: raw history per pad (bit 0 newest), accepted levels
    // {wake, mcu, fpga}, and a run length of "both buttons released".
    logic [HW-1:0] hist [3];
    logic [2:0]    m_acc;
    int            run_len;
    logic [1:0]    m_state;
    logic          m_soc, m_dwk, m_pulse, m_wake_prev;

    always #5 clk = ~clk;

    board_rst_wake_cond #(
        .DEBOUNCE_CYC(DEB),
        .RST_STRETCH (RS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fpga_rst_n_raw(fpga_rst_n_raw),
        .mcu_rst_n_raw (mcu_rst_n_raw),
        .wakeup_raw    (wakeup_raw),
        .soc_erst_n    (soc_erst_n),
        .dwakeup_n     (dwakeup_n),
        .wake_pulse    (wake_pulse),
        .rst_state     (rst_state)
    );

    function automatic logic [4:0] dut_vec();
        return {soc_erst_n, dwakeup_n, wake_pulse, rst_state};
    endfunction

    function automatic logic [4:0] model_vec();
        return {m_soc, m_dwk, m_pulse, m_state};
    endfunction

    task automatic model_reset();
        hist[0] = '1;
        hist[1] = '1;
        hist[2] = '0;
        m_acc = 3'b011;
        run_len = 0;
        m_state = 2'd0;
        m_soc = 1'b0;
        m_dwk = 1'b1;
        m_pulse = 1'b0;
        m_wake_prev = 1'b0;
    endtask

    // One clock edge: advance the model from pre-edge values, then settle.
    task automatic step();
        logic       ok_pre, wake_pre;
        logic [1:0] st_pre;
        logic [2:0] raw;
        @(posedge clk);
        raw = {wakeup_raw, mcu_rst_n_raw, fpga_rst_n_raw};
        ok_pre = m_acc[0] & m_acc[1];
        wake_pre = m_acc[2];
        st_pre = m_state;
        run_len = ok_pre ? ((run_len > RS) ? run_len : run_len + 1) : 0;
        m_state = !ok_pre ? 2'd0 : ((run_len > RS) ? 2'd2 : 2'd1);
        m_soc = (m_state == 2'd2);
        m_dwk = ~wake_pre;
        m_pulse = wake_pre & ~m_wake_prev & (st_pre == 2'd2);
        m_wake_prev = wake_pre;
        for (int i = 0; i < 3; i++) begin
            hist[i] = {hist[i][HW-2:0], raw[i]};
            if (hist[i][HW-1:SYNC] == {DEB{~m_acc[i]}}) m_acc[i] = ~m_acc[i];
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fpga_rst_n_raw = 1'b1;
        mcu_rst_n_raw = 1'b1;
        wakeup_raw = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== 5'b01000) begin
            errors++;
            $display("FAIL reset_vals got %b exp %b", dut_vec(), 5'b01000);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL powerup_model cyc %0d got %b exp %b", i, dut_vec(), model_vec());
            end
            checks++;
            if (soc_erst_n !== (i >= 5)) begin
                errors++;
                $display("FAIL powerup_stretch cyc %0d got %b exp %b", i, soc_erst_n, (i >= 5));
            end
        end
    endtask

    task automatic test_glitch();
        mcu_rst_n_raw = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            if (i == 8) mcu_rst_n_raw = 1'b1;
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL glitch_model cyc %0d got %b exp %b", i, dut_vec(), model_vec());
            end
            checks++;
            if (soc_erst_n !== 1'b1) begin
                errors++;
                $display("FAIL glitch_reject cyc %0d got %b exp 1", i, soc_erst_n);
            end
        end
        mcu_rst_n_raw = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step();
            checks++;
            if (soc_erst_n !== (i < SYNC + DEB + 1)) begin
                errors++;
                $display("FAIL press_latency cyc %0d got %b exp %b", i, soc_erst_n, (i < SYNC + DEB + 1));
            end
        end
        mcu_rst_n_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL glitch_release cyc %0d got %b exp %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_restretch();
        fpga_rst_n_raw = 1'b0;
        repeat (12) step();
        fpga_rst_n_raw = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            if (i == 5) mcu_rst_n_raw = 1'b0;
            if (i == 20) mcu_rst_n_raw = 1'b1;
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL restretch_model cyc %0d got %b exp %b", i, dut_vec(), model_vec());
            end
            if (i == 14) begin
                checks++;
                if (rst_state !== 2'd1) begin
                    errors++;
                    $display("FAIL restretch_in_stretch got %0d exp 1", rst_state);
                end
            end
            if (i == 15) begin
                checks++;
                if ({soc_erst_n, rst_state} !== 3'b000) begin
                    errors++;
                    $display("FAIL restretch_priority got %b exp 000", {soc_erst_n, rst_state});
                end
            end
            if (i == 33 || i == 34) begin
                checks++;
                if (soc_erst_n !== (i == 34)) begin
                    errors++;
                    $display("FAIL restretch_full cyc %0d got %b exp %b", i, soc_erst_n, (i == 34));
                end
            end
        end
    endtask

    task automatic test_wake_run();
        int np;
        np = 0;
        wakeup_raw = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 11) wakeup_raw = 1'b0;
            step();
            if (wake_pulse === 1'b1) np++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL wake_run_model cyc %0d got %b exp %b", i, dut_vec(), model_vec());
            end
            if (i == 10 || i == 11) begin
                checks++;
                if ({dwakeup_n, wake_pulse} !== ((i == 11) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL wake_run_edge cyc %0d got %b exp %b", i, {dwakeup_n, wake_pulse},
                             ((i == 11) ? 2'b01 : 2'b10));
                end
            end
        end
        checks++;
        if (np !== 1 || dwakeup_n !== 1'b1) begin
            errors++;
            $display("FAIL wake_run_count pulses %0d dwk %b exp pulses 1 dwk 1", np, dwakeup_n);
        end
    endtask

    task automatic test_wake_hold();
        int np;
        np = 0;
        mcu_rst_n_raw = 1'b0;
        repeat (12) step();
        wakeup_raw = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            if (i == 16) mcu_rst_n_raw = 1'b1;
            step();
            if (wake_pulse === 1'b1) np++;
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL wake_hold_model cyc %0d got %b exp %b", i, dut_vec(), model_vec());
            end
            if (i == 15) begin
                checks++;
                if ({dwakeup_n, rst_state} !== 3'b000) begin
                    errors++;
                    $display("FAIL wake_hold_level got %b exp 000", {dwakeup_n, rst_state});
                end
            end
        end
        checks++;
        if (np !== 0 || rst_state !== 2'd2 || dwakeup_n !== 1'b0) begin
            errors++;
            $display("FAIL wake_hold_nopulse pulses %0d state %0d dwk %b exp 0 2 0", np, rst_state, dwakeup_n);
        end
        wakeup_raw = 1'b0;
        repeat (15) step();
    endtask

    task automatic test_async_reset();
        int guard;
        wakeup_raw = 1'b1;
        mcu_rst_n_raw = 1'b0;
        repeat (12) step();
        mcu_rst_n_raw = 1'b1;
        guard = 0;
        while (m_state != 2'd1 && guard < 40) begin
            step();
            guard++;
        end
        step();
        checks++;
        if (guard >= 40 || rst_state !== 2'd1 || dwakeup_n !== 1'b0) begin
            errors++;
            $display("FAIL async_setup state %0d dwk %b exp 1 0", rst_state, dwakeup_n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 5'b01000) begin
            errors++;
            $display("FAIL async_reset got %b exp %b", dut_vec(), 5'b01000);
        end
        model_reset();
        wakeup_raw = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL async_recover cyc %0d got %b exp %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        int left [3];
        for (int k = 0; k < 3; k++) left[k] = $urandom_range(1, 20);
        for (int i = 1; i <= 1500; i++) begin
            for (int k = 0; k < 3; k++) begin
                left[k]--;
                if (left[k] <= 0) begin
                    left[k] = $urandom_range(1, 20);
                    case (k)
                        0: fpga_rst_n_raw = ~fpga_rst_n_raw;
                        1: mcu_rst_n_raw = ~mcu_rst_n_raw;
                        default: wakeup_raw = ~wakeup_raw;
                    endcase
                end
            end
            step();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_restretch();
        test_wake_run();
        test_wake_hold();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
